ftdi_write_ctrl: RTL and testbench
==================================

Name: ftdi_write_ctrl

Overview:
Transmit-side companion to the FTDI read controller. Drives the FT232H synchronous 245-FIFO write interface from a 60 MHz FTDI CLKOUT domain and takes bytes from an internal valid/ready stream through a 2-entry holding buffer. It yields the shared data bus whenever the read side owns it, and pulses SIWU# after a quiet period so short packets are flushed to the host.

Parameters:
FLUSH_TIMEOUT, 255, idle cycles after the last accepted byte before a SIWU# pulse; 0 disables flushing.
CNT_W, 8, width of the flush counter; must satisfy FLUSH_TIMEOUT < 2**CNT_W.

Ports:
clk_i  in  1  FTDI CLKOUT, 60 MHz; all logic on rising edge.
rst_n_i  in  1  Asynchronous reset, active-low.
data_i  in  8  Upstream byte.
valid_i  in  1  Upstream byte valid.
ready_o  out  1  Buffer can accept; a push occurs when valid_i && ready_o at a rising edge.
bus_busy_i  in  1  Read side owns the data bus (its OE# is asserted); high means release the bus.
txe_n_i  in  1  FTDI TXE#; low means the FTDI FIFO has space.
wr_n_o  out  1  FTDI WR#, registered.
data_o  out  8  Byte to the FTDI data bus, registered.
data_oe_o  out  1  Tristate enable for the data bus, registered; 1 means this block drives the bus.
siwu_n_o  out  1  FTDI SIWU#, registered; a 1-cycle low pulse flushes.

Behaviour:
- Reset (async, rst_n_i=0): wr_n_o=1, siwu_n_o=1, data_oe_o=0, data_o=0, buffer empty, ready_o=1, state IDLE, flush counter 0, flush disarmed.
- Buffer: 2-entry FIFO with count 0..2.
  - ready_o = (count != 2), combinational from registers only.
  - Push and pop in the same edge leaves count unchanged.
  - The buffer never overflows or underflows.
- Transfer definition: at a rising edge, a byte is accepted by the FTDI iff wr_n_o==0 && txe_n_i==0. The head entry pops at that edge.
  - When wr_n_o==0 and txe_n_i==1, the byte is NOT accepted. The head stays, and data_o holds unchanged until it is accepted.
- data_o always presents the current head entry (registered copy), updated the edge after a pop or after a push into an empty buffer.
- FSM states:
  - IDLE: data_oe_o=0, wr_n_o=1.
    - Go to TURN when count>0 && !bus_busy_i && !txe_n_i.
    - Else go to FLUSH when the flush condition holds.
  - TURN: exactly 1 cycle; data_oe_o=1, wr_n_o=1 (bus turnaround, data settles). Go to WRITE unless bus_busy_i=1, which returns to IDLE.
  - WRITE: data_oe_o=1.
    - Next wr_n_o=0 iff bus_busy_i==0 && txe_n_i==0 && (count after this edge's pop/push) > 0; else wr_n_o=1.
    - Go to IDLE when bus_busy_i=1, or when the buffer is empty after this edge.
    - A transfer at the leaving edge still counts.
    - With txe_n_i=1 (FTDI full), stay in WRITE with wr_n_o=1 while count>0 and !bus_busy_i.
  - FLUSH: siwu_n_o=0 for exactly 1 cycle, data_oe_o=0, wr_n_o=1; then IDLE.
- Flush condition:
  - Each transfer arms the flush and clears the counter.
  - While armed, in IDLE, with count==0, the counter increments each cycle.
  - When counter == FLUSH_TIMEOUT-1, go to FLUSH, then disarm and clear.
  - Any push clears the counter but keeps it armed.
  - FLUSH_TIMEOUT=0 never arms.
- Throughput: after TURN, one byte per cycle while TXE# is low and the buffer stays non-empty. From push into an empty buffer in IDLE to the first wr_n_o=0 is 3 edges (data_o load, TURN, WRITE).
- Bus priority: bus_busy_i always wins. data_oe_o and wr_n_o deassert on the first edge that samples bus_busy_i=1. This block never drives while bus_busy_i was sampled high.
- Reset mid-burst: outputs return to reset values immediately (async); buffered bytes are discarded.

Test Plan:
- Single byte: reset, push 0xA5 with txe_n_i=0, bus_busy_i=0 -> one edge with data_oe_o=1/wr_n_o=1 (TURN), then exactly one cycle wr_n_o=0 with data_o=0xA5, then data_oe_o=0. With FLUSH_TIMEOUT=4, siwu_n_o is low for exactly 1 cycle 4 cycles after that transfer.
- Burst: push 0x01..0x10 back-to-back with txe_n_i=0 -> 16 consecutive transfers in order with no gaps after TURN; ready_o never stalls valid_i for more than 0 cycles once streaming.
- FTDI full: mid-burst, raise txe_n_i for 5 cycles at byte 0x07 -> byte 0x07 is transferred exactly once after txe_n_i falls, no loss or duplication; ready_o=0 while count==2.
- Bus arbitration: assert bus_busy_i during a burst -> next edge wr_n_o=1, data_oe_o=0; release -> TURN cycle, then resume at the unsent byte.
- Reset mid-burst: assert rst_n_i=0 with count=2 -> wr_n_o=1, data_oe_o=0, siwu_n_o=1 asynchronously; after release ready_o=1 and no spurious writes.
- FLUSH_TIMEOUT=0: single byte sent -> siwu_n_o stays 1 for ≥300 cycles.

Source files
------------

// File: rtl/ftdi_write_ctrl.sv
// ftdi_write_ctrl: FT232H sync-245 write side with 2-entry buffer, bus yield and SIWU# flush
module ftdi_write_ctrl #(
  parameter int FLUSH_TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       bus_busy_i,
  input  logic       txe_n_i,
  output logic       wr_n_o,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  output logic       siwu_n_o
);
  typedef enum logic [1:0] {IDLE, TURN, WRITE, FLUSH} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FLUSH_TIMEOUT == 0 ? 0 : FLUSH_TIMEOUT - 1);
  state_t state, state_next;
  logic [1:0] count, count_next;
  logic [7:0] tail;
  logic [CNT_W-1:0] cnt;
  logic armed, push, pop, flush_hit;
  assign ready_o = count != 2'd2;
  assign push = valid_i && ready_o;
  assign pop = !wr_n_o && !txe_n_i;
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  assign flush_hit = armed && count == 2'd0 && cnt == LAST;
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = (count != 2'd0 && !bus_busy_i && !txe_n_i) ? TURN : flush_hit ? FLUSH : IDLE;
      TURN:    state_next = bus_busy_i ? IDLE : WRITE;
      WRITE:   state_next = (bus_busy_i || count_next == 2'd0) ? IDLE : WRITE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      count <= 2'd0;
      tail <= 8'd0;
      data_o <= 8'd0;
      wr_n_o <= 1'b1;
      data_oe_o <= 1'b0;
      siwu_n_o <= 1'b1;
      armed <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      data_oe_o <= state_next == TURN || state_next == WRITE;
      wr_n_o <= !(state_next == WRITE && !txe_n_i && count_next != 2'd0);
      siwu_n_o <= state_next != FLUSH;
      if (push && (count == 2'd0 || pop)) data_o <= data_i;
      else if (pop && count == 2'd2) data_o <= tail;
      if (push && count == 2'd1 && !pop) tail <= data_i;
      if (pop) begin
        armed <= FLUSH_TIMEOUT != 0;
        cnt <= '0;
      end else if (state_next == FLUSH) begin
        armed <= 1'b0;
        cnt <= '0;
      end else if (push) cnt <= '0;
      else if (armed && state == IDLE && count == 2'd0) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ftdi_write_ctrl.sv
// tb_ftdi_write_ctrl: randomized and directed self-checking bench for ftdi_write_ctrl
module tb_ftdi_write_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic valid = 1'b0, bb = 1'b0, txe_n = 1'b1;
  logic ready, wr_n, oe, siwu;
  logic [7:0] data_out;
  logic nf_ready, nf_wr_n, nf_oe, nf_siwu;
  logic [7:0] nf_data;
  int checks = 0, failures = 0;
  logic [7:0] model_q[$];
  logic [7:0] got[$];
  int nxt = 1;
  logic xfer_seen, underflow, bb_prev, pushed;
  logic [7:0] xfer_byte, exp_byte;

  always #5 clk = ~clk;

  ftdi_write_ctrl #(.FLUSH_TIMEOUT(4), .CNT_W(8)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_in), .valid_i(valid), .ready_o(ready),
    .bus_busy_i(bb), .txe_n_i(txe_n), .wr_n_o(wr_n), .data_o(data_out),
    .data_oe_o(oe), .siwu_n_o(siwu));

  ftdi_write_ctrl #(.FLUSH_TIMEOUT(0), .CNT_W(8)) u_nf (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_in), .valid_i(valid), .ready_o(nf_ready),
    .bus_busy_i(bb), .txe_n_i(txe_n), .wr_n_o(nf_wr_n), .data_o(nf_data),
    .data_oe_o(nf_oe), .siwu_n_o(nf_siwu));

  task automatic step();
    logic x, p, b;
    logic [7:0] d, din;
    x = !wr_n && !txe_n;
    p = valid && ready;
    b = bb;
    d = data_out;
    din = data_in;
    @(posedge clk);
    #1;
    xfer_seen = x;
    xfer_byte = d;
    bb_prev = b;
    pushed = p;
    underflow = 1'b0;
    exp_byte = 8'd0;
    if (x) begin
      if (model_q.size() == 0) underflow = 1'b1;
      else exp_byte = model_q.pop_front();
    end
    if (p) model_q.push_back(din);
  endtask

  task automatic stream_step();
    valid = nxt <= 16;
    data_in = 8'(nxt);
    step();
    if (pushed) nxt++;
    if (xfer_seen) got.push_back(xfer_byte);
  endtask

  function automatic int first_bad();
    if (got.size() != 16) return -2;
    for (int i = 0; i < 16; i++) if (got[i] != 8'(i + 1)) return i;
    return -1;
  endfunction

  task automatic do_reset();
    valid = 1'b0;
    bb = 1'b0;
    txe_n = 1'b1;
    rst_n = 1'b0;
    #3;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_q.delete();
    got.delete();
    nxt = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_n !== 1'b1 || siwu !== 1'b1 || oe !== 1'b0 || data_out !== 8'd0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: wr_n=%b siwu=%b oe=%b data=%h ready=%b, required 1 1 0 00 1", wr_n, siwu, oe, data_out, ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_q.delete();
  endtask

  task automatic test_single();
    int bad = 0;
    do_reset();
    txe_n = 1'b0;
    valid = 1'b1;
    data_in = 8'hA5;
    step();
    valid = 1'b0;
    checks++;
    if (data_out !== 8'hA5 || oe !== 1'b0 || wr_n !== 1'b1) begin
      failures++;
      $display("FAIL single_load: data=%h oe=%b wr_n=%b, required a5 0 1", data_out, oe, wr_n);
    end
    step();
    checks++;
    if (oe !== 1'b1 || wr_n !== 1'b1) begin
      failures++;
      $display("FAIL single_turn: oe=%b wr_n=%b, required 1 1", oe, wr_n);
    end
    step();
    checks++;
    if (oe !== 1'b1 || wr_n !== 1'b0 || data_out !== 8'hA5) begin
      failures++;
      $display("FAIL single_write: oe=%b wr_n=%b data=%h, required 1 0 a5", oe, wr_n, data_out);
    end
    step();
    checks++;
    if (!xfer_seen || xfer_byte !== 8'hA5 || oe !== 1'b0 || wr_n !== 1'b1) begin
      failures++;
      $display("FAIL single_done: xfer=%b byte=%h oe=%b wr_n=%b, required 1 a5 0 1", xfer_seen, xfer_byte, oe, wr_n);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      if (siwu !== (k == 4 ? 1'b0 : 1'b1) || wr_n !== 1'b1 || nf_siwu !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_flush: %0d cycles wrong, required siwu low only 4 cycles after transfer", bad);
    end
  endtask

  task automatic test_burst();
    int stall = 0, gap = 0;
    do_reset();
    txe_n = 1'b0;
    for (int i = 0; i < 80 && got.size() < 16; i++) begin
      if (got.size() > 0 && nxt <= 16 && !ready) stall++;
      stream_step();
      if (got.size() > 0 && got.size() < 16 && !xfer_seen) gap++;
    end
    checks++;
    if (first_bad() != -1) begin
      failures++;
      $display("FAIL burst_order: %0d bytes, first bad index %0d, required 01..10 in order", got.size(), first_bad());
    end
    checks++;
    if (gap != 0 || stall != 0) begin
      failures++;
      $display("FAIL burst_rate: gaps=%0d stalls=%0d, required 0 0", gap, stall);
    end
  endtask

  task automatic test_full();
    int hold = 0, bad_hold = 0, bad_ready = 0;
    logic stalled = 1'b0, saw_full = 1'b0;
    do_reset();
    txe_n = 1'b0;
    for (int i = 0; i < 100 && got.size() < 16; i++) begin
      if (!stalled && !wr_n && data_out == 8'h07) begin
        hold = 5;
        stalled = 1'b1;
      end
      txe_n = hold > 0;
      stream_step();
      if (hold > 0) begin
        hold--;
        if (data_out !== 8'h07) bad_hold++;
      end
      if (ready !== (model_q.size() != 2)) bad_ready++;
      if (model_q.size() == 2 && !ready) saw_full = 1'b1;
    end
    txe_n = 1'b0;
    checks++;
    if (first_bad() != -1 || !stalled) begin
      failures++;
      $display("FAIL full_order: %0d bytes, first bad index %0d, stalled=%b, required 01..10 once each", got.size(), first_bad(), stalled);
    end
    checks++;
    if (bad_hold != 0) begin
      failures++;
      $display("FAIL full_hold: data changed %0d times while TXE# high, required 07 held", bad_hold);
    end
    checks++;
    if (bad_ready != 0 || !saw_full) begin
      failures++;
      $display("FAIL full_ready: ready errors=%0d saw_full=%b, required 0 1", bad_ready, saw_full);
    end
  endtask

  task automatic test_bus();
    int bad = 0;
    logic [7:0] exp;
    do_reset();
    txe_n = 1'b0;
    for (int i = 0; i < 40 && got.size() < 5; i++) stream_step();
    bb = 1'b1;
    repeat (3) begin
      stream_step();
      if (oe !== 1'b0 || wr_n !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bus_yield: %0d busy cycles driving, required oe=0 wr_n=1", bad);
    end
    bb = 1'b0;
    stream_step();
    checks++;
    if (oe !== 1'b1 || wr_n !== 1'b1) begin
      failures++;
      $display("FAIL bus_turn: oe=%b wr_n=%b, required 1 1", oe, wr_n);
    end
    exp = 8'(got.size() + 1);
    stream_step();
    checks++;
    if (wr_n !== 1'b0 || data_out !== exp) begin
      failures++;
      $display("FAIL bus_resume: wr_n=%b data=%h, required 0 %h", wr_n, data_out, exp);
    end
    for (int i = 0; i < 60 && got.size() < 16; i++) stream_step();
    checks++;
    if (first_bad() != -1) begin
      failures++;
      $display("FAIL bus_order: %0d bytes, first bad index %0d, required 01..10 in order", got.size(), first_bad());
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    txe_n = 1'b0;
    valid = 1'b1;
    data_in = 8'h11;
    step();
    data_in = 8'h22;
    step();
    valid = 1'b0;
    step();
    checks++;
    if (ready !== 1'b0 || wr_n !== 1'b0 || oe !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: ready=%b wr_n=%b oe=%b, required 0 0 1", ready, wr_n, oe);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wr_n !== 1'b1 || oe !== 1'b0 || siwu !== 1'b1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_async: wr_n=%b oe=%b siwu=%b ready=%b, required 1 0 1 1", wr_n, oe, siwu, ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_q.delete();
    repeat (10) begin
      step();
      if (wr_n !== 1'b1 || oe !== 1'b0 || ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_after: %0d bad cycles, required idle wr_n=1 oe=0 ready=1", bad);
    end
  endtask

  task automatic test_no_flush();
    int nf_low = 0, nf_wr = 0, low = 0;
    do_reset();
    txe_n = 1'b0;
    valid = 1'b1;
    data_in = 8'h3C;
    step();
    valid = 1'b0;
    repeat (320) begin
      step();
      if (nf_siwu !== 1'b1) nf_low++;
      if (nf_wr_n === 1'b0) nf_wr++;
      if (siwu === 1'b0) low++;
    end
    checks++;
    if (nf_low != 0 || nf_wr != 1) begin
      failures++;
      $display("FAIL noflush_siwu: siwu low %0d cycles, writes %0d, required 0 and 1", nf_low, nf_wr);
    end
    checks++;
    if (low != 1) begin
      failures++;
      $display("FAIL flush_once: siwu low %0d cycles, required 1", low);
    end
  endtask

  task automatic test_random();
    int xfers = 0;
    do_reset();
    txe_n = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom % 4) != 0;
      data_in = 8'($urandom);
      bb = ($urandom % 16) == 0;
      if (($urandom % 8) == 0) txe_n = ~txe_n;
      step();
      if (xfer_seen) begin
        xfers++;
        checks++;
        if (underflow || xfer_byte !== exp_byte) begin
          failures++;
          $display("FAIL rand_data: cycle %0d byte=%h underflow=%b, required %h", i, xfer_byte, underflow, exp_byte);
        end
      end
      checks++;
      if (ready !== (model_q.size() != 2)) begin
        failures++;
        $display("FAIL rand_ready: cycle %0d ready=%b, required %b", i, ready, model_q.size() != 2);
      end
      if (bb_prev) begin
        checks++;
        if (oe !== 1'b0 || wr_n !== 1'b1) begin
          failures++;
          $display("FAIL rand_busy: cycle %0d oe=%b wr_n=%b, required 0 1", i, oe, wr_n);
        end
      end
      if (wr_n === 1'b0) begin
        checks++;
        if (oe !== 1'b1 || model_q.size() == 0) begin
          failures++;
          $display("FAIL rand_wr: cycle %0d oe=%b depth=%0d, required oe=1 depth>0", i, oe, model_q.size());
        end
      end
      if (siwu === 1'b0) begin
        checks++;
        if (oe !== 1'b0 || wr_n !== 1'b1) begin
          failures++;
          $display("FAIL rand_siwu: cycle %0d oe=%b wr_n=%b, required 0 1", i, oe, wr_n);
        end
      end
      checks++;
      if (nf_siwu !== 1'b1) begin
        failures++;
        $display("FAIL rand_noflush: cycle %0d siwu=%b, required 1", i, nf_siwu);
      end
    end
    valid = 1'b0;
    bb = 1'b0;
    txe_n = 1'b0;
    for (int i = 0; i < 20 && model_q.size() != 0; i++) begin
      step();
      if (xfer_seen) begin
        xfers++;
        checks++;
        if (underflow || xfer_byte !== exp_byte) begin
          failures++;
          $display("FAIL drain_data: byte=%h, required %h", xfer_byte, exp_byte);
        end
      end
    end
    checks++;
    if (model_q.size() != 0 || xfers < 100) begin
      failures++;
      $display("FAIL rand_progress: left=%0d transfers=%0d, required 0 and >=100", model_q.size(), xfers);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_bus();
    test_reset_mid();
    test_no_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
